// File: rtl/pipe_ctrl.sv
// rtl/pipe_ctrl.sv - pipeline stall/bubble/flush controller with stall timeout watchdog
// Optional perf counters enabled by defining PIPE_CTRL_PERF_EN.
module pipe_ctrl #(
    parameter int STAGES    = 6,
    parameter int TIMEOUT_W = 8,
    parameter int PC_W      = 32
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic [STAGES-1:0] stallreq,
    input  logic              flush_req,
    input  logic [PC_W-1:0]   flush_pc,
    output logic [STAGES-1:0] stall,
    output logic [STAGES-1:0] bubble,
    output logic              flush,
    output logic [PC_W-1:0]   flush_pc_o,
    output logic              stall_timeout,
`ifdef PIPE_CTRL_PERF_EN
    output logic [31:0]       perf_stall_cyc,
    output logic [31:0]       perf_flush_cnt,
`endif
    output logic [1:0]        ctrl_state
);

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_STALL = 2'd1,
        ST_FLUSH = 2'd2
    } state_e;

    localparam logic [TIMEOUT_W-1:0] CNT_MAX = {TIMEOUT_W{1'b1}};

    state_e               state_q, state_d;
    logic [TIMEOUT_W-1:0] cnt_q, cnt_d;
    logic [PC_W-1:0]      flush_pc_q;
    logic                 timeout_q;
    logic [STAGES-1:0]    prefix;
    logic                 any_req;

    assign any_req = |stallreq;

    // stall[j] is set when any stage at or above j requests a hold; the bubble
    // goes into the first stage above the highest holding one.
    always_comb begin
        logic acc;
        acc    = 1'b0;
        prefix = '0;
        for (int j = STAGES - 1; j >= 0; j--) begin
            acc       = acc | stallreq[j];
            prefix[j] = acc;
        end
    end

    always_comb begin
        stall  = '0;
        bubble = '0;
        if (resetn && state_q != ST_FLUSH) begin
            stall = prefix;
            for (int j = 1; j < STAGES; j++) begin
                bubble[j] = prefix[j-1] & ~prefix[j];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        if (flush_req) begin
            state_d = ST_FLUSH;
        end else if (any_req) begin
            state_d = ST_STALL;
        end else begin
            state_d = ST_RUN;
        end
        cnt_d = '0;
        if (state_d == ST_STALL) begin
            cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q    <= ST_RUN;
            cnt_q      <= '0;
            flush_pc_q <= '0;
            timeout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (flush_req) begin
                flush_pc_q <= flush_pc;
            end
            if (cnt_d == CNT_MAX) begin
                timeout_q <= 1'b1;
            end
        end
    end

    assign flush         = (state_q == ST_FLUSH);
    assign flush_pc_o    = flush_pc_q;
    assign stall_timeout = timeout_q;
    assign ctrl_state    = state_q;

`ifdef PIPE_CTRL_PERF_EN
    logic [31:0] perf_stall_q, perf_flush_q;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            perf_stall_q <= '0;
            perf_flush_q <= '0;
        end else begin
            if (|stall) begin
                perf_stall_q <= perf_stall_q + 32'd1;
            end
            if (flush) begin
                perf_flush_q <= perf_flush_q + 32'd1;
            end
        end
    end

    assign perf_stall_cyc = perf_stall_q;
    assign perf_flush_cnt = perf_flush_q;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb/tb_pipe_ctrl.sv - directed self-checking bench for pipe_ctrl (TIMEOUT_W=4)
module tb_pipe_ctrl;

    logic        clk;
    logic        resetn;
    logic [5:0]  stallreq;
    logic        flush_req;
    logic [31:0] flush_pc;
    logic [5:0]  stall;
    logic [5:0]  bubble;
    logic        flush;
    logic [31:0] flush_pc_o;
    logic        stall_timeout;
    logic [1:0]  ctrl_state;
`ifdef PIPE_CTRL_PERF_EN
    logic [31:0] perf_stall_cyc;
    logic [31:0] perf_flush_cnt;
`endif

    int checks = 0;
    int errors = 0;

    pipe_ctrl #(.STAGES(6), .TIMEOUT_W(4), .PC_W(32)) dut (
        .clk          (clk),
        .resetn       (resetn),
        .stallreq     (stallreq),
        .flush_req    (flush_req),
        .flush_pc     (flush_pc),
        .stall        (stall),
        .bubble       (bubble),
        .flush        (flush),
        .flush_pc_o   (flush_pc_o),
        .stall_timeout(stall_timeout),
`ifdef PIPE_CTRL_PERF_EN
        .perf_stall_cyc(perf_stall_cyc),
        .perf_flush_cnt(perf_flush_cnt),
`endif
        .ctrl_state   (ctrl_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        resetn    = 1'b0;
        stallreq  = '0;
        flush_req = 1'b0;
        flush_pc  = '0;
        step();
        resetn = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        resetn    = 1'b0;
        stallreq  = 6'h3F;
        flush_req = 1'b1;
        flush_pc  = 32'hDEADBEEF;
        step(); step(); step();
        checks++; if (stall !== 6'h00) begin errors++; $display("FAIL reset_stall: got %b want %b", stall, 6'h00); end
        checks++; if (bubble !== 6'h00) begin errors++; $display("FAIL reset_bubble: got %b want %b", bubble, 6'h00); end
        checks++; if (flush !== 1'b0) begin errors++; $display("FAIL reset_flush: got %b want 0", flush); end
        checks++; if (ctrl_state !== 2'd0) begin errors++; $display("FAIL reset_state: got %0d want 0", ctrl_state); end
        checks++; if (stall_timeout !== 1'b0) begin errors++; $display("FAIL reset_timeout: got %b want 0", stall_timeout); end
        checks++; if (flush_pc_o !== 32'h0) begin errors++; $display("FAIL reset_pc: got %h want 0", flush_pc_o); end
        stallreq  = '0;
        flush_req = 1'b0;
        resetn    = 1'b1;
        step();
    endtask

    task automatic test_id_stall();
        stallreq = 6'b000100;
        #1;
        checks++; if (stall !== 6'b000111) begin errors++; $display("FAIL id_stall: got %b want %b", stall, 6'b000111); end
        checks++; if (bubble !== 6'b001000) begin errors++; $display("FAIL id_bubble: got %b want %b", bubble, 6'b001000); end
        step();
        checks++; if (ctrl_state !== 2'd1) begin errors++; $display("FAIL id_state_stall: got %0d want 1", ctrl_state); end
        stallreq = '0;
        #1;
        checks++; if (stall !== 6'b000000) begin errors++; $display("FAIL id_release: got %b want 0", stall); end
        step();
        checks++; if (ctrl_state !== 2'd0) begin errors++; $display("FAIL id_state_run: got %0d want 0", ctrl_state); end
    endtask

    task automatic test_multi();
        stallreq = 6'b010010;
        #1;
        checks++; if (stall !== 6'b011111) begin errors++; $display("FAIL multi_stall: got %b want %b", stall, 6'b011111); end
        checks++; if (bubble !== 6'b100000) begin errors++; $display("FAIL multi_bubble: got %b want %b", bubble, 6'b100000); end
        step();
        stallreq = 6'b100000;
        #1;
        checks++; if (stall !== 6'h3F) begin errors++; $display("FAIL wb_stall: got %b want %b", stall, 6'h3F); end
        checks++; if (bubble !== 6'h00) begin errors++; $display("FAIL wb_bubble: got %b want 0", bubble); end
        stallreq = 6'b000001;
        #1;
        checks++; if (stall !== 6'b000001) begin errors++; $display("FAIL pc_stall: got %b want %b", stall, 6'b000001); end
        checks++; if (bubble !== 6'b000010) begin errors++; $display("FAIL pc_bubble: got %b want %b", bubble, 6'b000010); end
        step();
        stallreq = '0;
        step();
        checks++; if (ctrl_state !== 2'd0) begin errors++; $display("FAIL multi_state: got %0d want 0", ctrl_state); end
    endtask

    task automatic test_flush_over_stall();
        flush_req = 1'b1;
        flush_pc  = 32'hBFC00380;
        stallreq  = 6'b000100;
        step();
        flush_req = 1'b0;
        flush_pc  = 32'h0;
        #1;
        checks++; if (flush !== 1'b1) begin errors++; $display("FAIL fos_flush: got %b want 1", flush); end
        checks++; if (flush_pc_o !== 32'hBFC00380) begin errors++; $display("FAIL fos_pc: got %h want %h", flush_pc_o, 32'hBFC00380); end
        checks++; if (stall !== 6'h00) begin errors++; $display("FAIL fos_stall: got %b want 0", stall); end
        checks++; if (bubble !== 6'h00) begin errors++; $display("FAIL fos_bubble: got %b want 0", bubble); end
        checks++; if (ctrl_state !== 2'd2) begin errors++; $display("FAIL fos_state_flush: got %0d want 2", ctrl_state); end
        step();
        checks++; if (ctrl_state !== 2'd1) begin errors++; $display("FAIL fos_state_stall: got %0d want 1", ctrl_state); end
        checks++; if (stall !== 6'b000111) begin errors++; $display("FAIL fos_stall_after: got %b want %b", stall, 6'b000111); end
        checks++; if (flush !== 1'b0) begin errors++; $display("FAIL fos_flush_after: got %b want 0", flush); end
        stallreq = '0;
        step();
    endtask

    task automatic test_timeout();
        pulse_reset();
        stallreq = 6'b001000;
        for (int i = 0; i < 14; i++) step();
        checks++; if (stall_timeout !== 1'b0) begin errors++; $display("FAIL timeout_early: got %b want 0 after 14 edges", stall_timeout); end
        step();
        checks++; if (stall_timeout !== 1'b1) begin errors++; $display("FAIL timeout_set: got %b want 1 after 15 edges", stall_timeout); end
        step(); step();
        stallreq = '0;
        step(); step(); step();
        checks++; if (ctrl_state !== 2'd0) begin errors++; $display("FAIL timeout_state: got %0d want 0", ctrl_state); end
        checks++; if (stall_timeout !== 1'b1) begin errors++; $display("FAIL timeout_sticky: got %b want 1", stall_timeout); end
        pulse_reset();
        checks++; if (stall_timeout !== 1'b0) begin errors++; $display("FAIL timeout_clear: got %b want 0", stall_timeout); end
    endtask

    task automatic test_short_stalls();
        for (int r = 0; r < 3; r++) begin
            stallreq = 6'b001000;
            for (int i = 0; i < 10; i++) step();
            stallreq = '0;
            step();
        end
        checks++; if (stall_timeout !== 1'b0) begin errors++; $display("FAIL counter_clear: got %b want 0", stall_timeout); end
    endtask

    task automatic test_back_to_back();
        pulse_reset();
        flush_req = 1'b1;
        flush_pc  = 32'h100;
        step();
        flush_pc = 32'h200;
        #1;
        checks++; if (flush !== 1'b1) begin errors++; $display("FAIL b2b_flush1: got %b want 1", flush); end
        checks++; if (flush_pc_o !== 32'h100) begin errors++; $display("FAIL b2b_pc1: got %h want %h", flush_pc_o, 32'h100); end
        step();
        flush_req = 1'b0;
        #1;
        checks++; if (flush !== 1'b1) begin errors++; $display("FAIL b2b_flush2: got %b want 1", flush); end
        checks++; if (flush_pc_o !== 32'h200) begin errors++; $display("FAIL b2b_pc2: got %h want %h", flush_pc_o, 32'h200); end
        step();
        checks++; if (flush !== 1'b0) begin errors++; $display("FAIL b2b_flush_end: got %b want 0", flush); end
        checks++; if (ctrl_state !== 2'd0) begin errors++; $display("FAIL b2b_state: got %0d want 0", ctrl_state); end
`ifdef PIPE_CTRL_PERF_EN
        checks++; if (perf_flush_cnt !== 32'd2) begin errors++; $display("FAIL b2b_perf_flush: got %0d want 2", perf_flush_cnt); end
        checks++; if (perf_stall_cyc !== 32'd0) begin errors++; $display("FAIL b2b_perf_stall: got %0d want 0", perf_stall_cyc); end
`endif
    endtask

    task automatic test_reset_mid_flush();
        flush_req = 1'b1;
        flush_pc  = 32'h1234;
        step();
        flush_req = 1'b0;
        resetn    = 1'b0;
        #1;
        checks++; if (flush !== 1'b0) begin errors++; $display("FAIL rmf_flush: got %b want 0", flush); end
        checks++; if (flush_pc_o !== 32'h0) begin errors++; $display("FAIL rmf_pc: got %h want 0", flush_pc_o); end
        resetn = 1'b1;
        step();
    endtask

    initial begin
        resetn    = 1'b0;
        stallreq  = '0;
        flush_req = 1'b0;
        flush_pc  = '0;
        test_reset();
        test_id_stall();
        test_multi();
        test_flush_over_stall();
        test_timeout();
        test_short_stalls();
        test_back_to_back();
        test_reset_mid_flush();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
